dmem_ctrl: RTL

//  Backing data-memory controller on the memory side of the data cache.
//  - Serves cache-line fills (load requests) and line write-backs (store requests) with a fixed, programmable latency.
//  - Holds a line-wide RAM array.
//  - Runs one transaction at a time and answers each with a single-cycle ready pulse.

---
 rtl/dmem_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
// Line-wide backing data memory for the data cache: serves one line fill or
// write-back at a time with a fixed latency and a single-cycle ready pulse.
module dmem_ctrl #(
    parameter int ADDR_BITS = 20,
    parameter int LINE_BITS = 128,
    parameter int DEPTH     = 1024,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ldp,
    input  logic                 stp,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [LINE_BITS-1:0] stData,
    output logic                 ldr,
    output logic [LINE_BITS-1:0] ldData,
    output logic                 str,
    output logic                 busy
);

    localparam int IDX_BITS = $clog2(DEPTH);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic                   accept_s;
    logic                   done_s;
    logic                   wr_en_s;
    logic [7:0]             count_r;
    logic                   op_st_r;
    logic [IDX_BITS-1:0]    idx_r;
    logic [LINE_BITS-1:0]   data_r;
    logic                   ldr_r;
    logic                   str_r;
    logic                   busy_r;
    logic [LINE_BITS-1:0]   ldData_r;
    logic [LINE_BITS-1:0]   mem_r [DEPTH];

    // Offset bits and bits above the index do not select a line.
    logic unused_addr_s;
    assign unused_addr_s = ^{addr[3:0], addr[ADDR_BITS-1:4+IDX_BITS]};

    // Next-state logic: accept in IDLE, count down in BUSY, one RESP cycle.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (stp || ldp) begin
                    accept_s = 1'b1;
                    state_s  = BUSY;
                end else begin
                    state_s  = IDLE;
                end
            end
            BUSY: begin
                if (count_r == 8'd0) begin
                    done_s  = 1'b1;
                    state_s = RESP;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    assign wr_en_s = done_s && op_st_r;

    // Control state, request latches and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            count_r  <= 8'd0;
            op_st_r  <= 1'b0;
            idx_r    <= '0;
            data_r   <= '0;
            ldr_r    <= 1'b0;
            str_r    <= 1'b0;
            busy_r   <= 1'b0;
            ldData_r <= '0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            ldr_r   <= done_s && !op_st_r;
            str_r   <= done_s && op_st_r;
            if (accept_s) begin
                // Store wins a simultaneous request; the load stays pending.
                op_st_r <= stp;
                idx_r   <= addr[4+IDX_BITS-1:4];
                data_r  <= stData;
                count_r <= CNT_INIT;
            end else if (state_r == BUSY && count_r != 8'd0) begin
                count_r <= count_r - 8'd1;
            end
            if (done_s && !op_st_r) begin
                ldData_r <= mem_r[idx_r];
            end
        end
    end

    // Line array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_r] <= data_r;
        end
    end

    assign ldr    = ldr_r;
    assign str    = str_r;
    assign busy   = busy_r;
    assign ldData = ldData_r;

endmodule
